intpol_seq_ctrl: RTL and testbench

- Sequencing controller for the interpolator sample window: a 3-deep delay line built from the team's enable/clear registers.
- Accepts input samples over a valid/ready handshake and drives the delay-line shift-enable and clear.
- After each window update, steps a phase counter through FACTOR output phases.
- Downstream polynomial datapath consumes phase_o under its own valid/ready handshake.

---
 rtl/intpol_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_intpol_seq_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/intpol_seq_ctrl.sv
// Sequencing controller for the interpolator sample window: fills a TAPS-deep
// delay line, then emits FACTOR phases per window update to the polynomial datapath.
module intpol_seq_ctrl #(
  parameter int FACTOR_WIDTH = 8,
  parameter int TAPS         = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    clrh,
  input  logic                    enable_i,
  input  logic [FACTOR_WIDTH-1:0] cfg_factor_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic                    dl_shift_o,
  output logic                    dl_clr_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [FACTOR_WIDTH-1:0] phase_o,
  output logic                    out_last_o,
  output logic                    busy_o,
  output logic [CNT_WIDTH-1:0]    frame_cnt_o,
  output logic [1:0]              dbg_state_o
);

  localparam int FILL_W = $clog2(TAPS + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_LOAD = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [FACTOR_WIDTH-1:0] phase_q, phase_d;
  logic [FACTOR_WIDTH-1:0] factor_q, factor_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [CNT_WIDTH-1:0]    frame_q, frame_d;

  logic                    accept;
  logic                    xfer;
  logic [FACTOR_WIDTH-1:0] last_phase;

  // Both handshakes: a transfer happens on a cycle where valid and ready are
  // high together at the rising edge; ready never depends on valid, and once
  // out_valid_o is raised it holds with a stable phase_o until out_ready_i.
  assign last_phase = factor_q - FACTOR_WIDTH'(1);
  assign accept     = valid_i & ready_o;
  assign xfer       = out_valid_o & out_ready_i;
  assign dl_shift_o = accept;
  assign busy_o     = (state_q != S_IDLE);
  assign frame_cnt_o = frame_q;
  assign dbg_state_o = state_q;
  assign phase_o    = (state_q == S_RUN) ? phase_q : '0;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    factor_d = factor_q;
    fill_d   = fill_q;
    frame_d  = frame_q;

    ready_o     = enable_i & ((state_q == S_FILL) | (state_q == S_LOAD));
    out_valid_o = enable_i & (state_q == S_RUN);
    out_last_o  = out_valid_o & (phase_q == last_phase);
    // Clear the delay line when a run starts and whenever a run is abandoned.
    dl_clr_o    = (state_q == S_IDLE) ? enable_i : ~enable_i;

    if (state_q != S_IDLE && !enable_i) begin
      state_d = S_IDLE;
      phase_d = '0;
      fill_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable_i) begin
            factor_d = (cfg_factor_i == '0) ? FACTOR_WIDTH'(1) : cfg_factor_i;
            fill_d   = '0;
            phase_d  = '0;
            state_d  = S_FILL;
          end
        end
        S_FILL: begin
          if (accept) begin
            fill_d = fill_q + FILL_W'(1);
            if (fill_q == FILL_LAST) begin
              phase_d = '0;
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (phase_q == last_phase) begin
              phase_d = '0;
              frame_d = frame_q + CNT_WIDTH'(1);
              state_d = S_LOAD;
            end else begin
              phase_d = phase_q + FACTOR_WIDTH'(1);
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            phase_d = '0;
            state_d = S_RUN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clrh) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      factor_q <= '0;
      fill_q   <= '0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      factor_q <= factor_d;
      fill_q   <= fill_d;
      frame_q  <= frame_d;
    end
  end

endmodule

// File: tb/tb_intpol_seq_ctrl.sv
// Bench for intpol_seq_ctrl: directed scenarios plus random traffic, checked
// against a transaction-level model holding the queue of phases still owed.
module tb_intpol_seq_ctrl;

  localparam int FW   = 8;
  localparam int TAPS = 3;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          clrh;
  logic          enable_i;
  logic [FW-1:0] cfg_factor_i;
  logic          valid_i;
  logic          ready_o;
  logic          dl_shift_o;
  logic          dl_clr_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [FW-1:0] phase_o;
  logic          out_last_o;
  logic          busy_o;
  logic [CW-1:0] frame_cnt_o;
  logic [1:0]    dbg_state_o;

  intpol_seq_ctrl #(.FACTOR_WIDTH(FW), .TAPS(TAPS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .clrh(clrh), .enable_i(enable_i), .cfg_factor_i(cfg_factor_i),
    .valid_i(valid_i), .ready_o(ready_o), .dl_shift_o(dl_shift_o),
    .dl_clr_o(dl_clr_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .phase_o(phase_o), .out_last_o(out_last_o), .busy_o(busy_o),
    .frame_cnt_o(frame_cnt_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: run active flag, latched factor, accept count since the
  // run started, phases still owed downstream, and completed sweeps.
  bit            m_active = 1'b0;
  int            m_fac    = 1;
  int            m_accepts = 0;
  logic [FW-1:0] exp_q[$];
  logic [CW-1:0] m_frames = '0;

  int  cyc_no      = 0;
  int  last_cyc    = -1;
  bit  track_period = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc_no);
    end
  endtask

  // One clock: apply inputs, compare outputs mid-cycle, advance the model.
  task automatic cyc(input logic c, input logic e, input logic v, input logic o,
                     input logic [FW-1:0] cf, input bit chk);
    logic e_ready, e_ov, e_clr, e_last;
    logic [FW-1:0] head;
    clrh = c; enable_i = e; valid_i = v; out_ready_i = o; cfg_factor_i = cf;
    @(negedge clk);
    e_ready = m_active && e && (exp_q.size() == 0);
    e_ov    = m_active && e && (exp_q.size() != 0);
    e_clr   = m_active ? !e : e;
    head    = (exp_q.size() != 0) ? exp_q[0] : '0;
    e_last  = e_ov && (int'(head) == m_fac - 1);
    if (chk) begin
      check("busy", busy_o, m_active);
      check("ready", ready_o, e_ready);
      check("out_valid", out_valid_o, e_ov);
      check("dl_clr", dl_clr_o, e_clr);
      check("dl_shift", dl_shift_o, v && e_ready);
      check("out_last", out_last_o, e_last);
      check("frame_cnt", frame_cnt_o, m_frames);
      if (e_ov) check("phase", phase_o, head);
      if (out_last_o && track_period && last_cyc >= 0)
        check("period", cyc_no - last_cyc, m_fac + 1);
    end
    if (out_last_o) last_cyc = cyc_no;
    @(posedge clk);
    if (c) begin
      m_active = 1'b0; exp_q.delete(); m_frames = '0;
    end else if (!m_active) begin
      if (e) begin
        m_active = 1'b1; m_accepts = 0;
        m_fac = (cf == 0) ? 1 : int'(cf);
      end
    end else if (!e) begin
      m_active = 1'b0; exp_q.delete();
    end else begin
      if (e_ov && o) begin
        if (int'(exp_q.pop_front()) == m_fac - 1) m_frames = m_frames + 1'b1;
      end
      if (v && e_ready) begin
        m_accepts++;
        if (m_accepts >= TAPS)
          for (int i = 0; i < m_fac; i++) exp_q.push_back(FW'(i));
      end
    end
    cyc_no++;
    #1;
  endtask

  initial begin
    clrh = 1'b1; enable_i = 1'b0; valid_i = 1'b0; out_ready_i = 1'b0; cfg_factor_i = '0;
    // Reset and initial fill with factor 4.
    cyc(1, 0, 0, 0, 8'd4, 0);
    cyc(1, 0, 0, 0, 8'd4, 1);
    check("rst_frame", frame_cnt_o, 0);
    check("rst_busy", busy_o, 0);
    cyc(0, 1, 0, 0, 8'd4, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 8'd9, 1);
    check("fill_outvalid", out_valid_o, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 8'd9, 1);
    check("first_frame", frame_cnt_o, 1);

    // Steady state: five more samples, downstream always ready.
    track_period = 1'b1;
    for (int s = 0; s < 5; s++) begin
      cyc(0, 1, 1, 0, 8'd2, 1);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 8'd2, 1);
    end
    track_period = 1'b0;
    check("steady_frame", frame_cnt_o, 6);

    // Downstream stall at phase 2.
    cyc(0, 1, 1, 0, 8'd4, 1);
    cyc(0, 1, 0, 1, 8'd4, 1);
    cyc(0, 1, 0, 1, 8'd4, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 8'd4, 1);
      check("stall_phase", phase_o, 2);
    end
    cyc(0, 1, 0, 1, 8'd4, 1);
    cyc(0, 1, 0, 1, 8'd4, 1);
    check("stall_frame", frame_cnt_o, 7);

    // Upstream starvation in LOAD, then one sample.
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 8'd4, 1);
    cyc(0, 1, 1, 1, 8'd4, 1);

    // Abort at RUN phase 1.
    cyc(0, 1, 0, 1, 8'd4, 1);
    cyc(0, 0, 0, 1, 8'd4, 1);
    check("abort_busy", busy_o, 0);
    check("abort_frame", frame_cnt_o, 7);

    // Re-enable with factor 0, treated as 1.
    cyc(0, 1, 0, 1, 8'd0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 8'd0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 1, 8'd5, 1);
      cyc(0, 1, 1, 1, 8'd5, 1);
    end
    check("fac1_last", out_last_o, 1);
    cyc(0, 0, 0, 1, 8'd5, 1);
    check("fac1_frame", frame_cnt_o, 11);

    // Reset mid-FILL with one sample in.
    cyc(0, 1, 0, 1, 8'd2, 1);
    cyc(0, 1, 1, 1, 8'd2, 1);
    cyc(1, 1, 1, 1, 8'd2, 1);
    check("clr_frame", frame_cnt_o, 0);
    check("clr_busy", busy_o, 0);
    cyc(0, 1, 0, 1, 8'd2, 1);
    cyc(0, 1, 1, 1, 8'd2, 1);
    cyc(0, 1, 1, 1, 8'd2, 1);
    cyc(0, 1, 0, 1, 8'd2, 1);
    cyc(0, 1, 1, 1, 8'd2, 1);
    cyc(0, 1, 0, 1, 8'd2, 1);
    cyc(0, 1, 0, 1, 8'd2, 1);
    check("refill_frame", frame_cnt_o, 1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 39) != 0),
          ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 3) != 0),
          FW'($urandom_range(0, 5)), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
